wb_sdram_arbiter: RTL and testbench
===================================

# wb_sdram_arbiter

Two-master round-robin Wishbone arbiter that shares the single Wishbone slave port of `sdrc_top` between two requesters, e.g. a CPU data port and a DMA engine. It sits between the masters and the SDRAM controller on the `wb_clk_i` domain. It locks the grant for a master's whole `cyc` cycle, including SDRAM bursts, and alternates fairly between masters. A watchdog terminates any granted transfer the controller fails to acknowledge.

## Interface
- `dw`, 32, Wishbone data width.
- `aw`, 26, Wishbone byte-address width.
- `TIMEOUT`, 1024, cycles of unacknowledged `stb` before error termination; legal range 2..65535.
- `wb_clk_i`  in  1  system clock; all logic on rising edge.
- `wb_rst_n`  in  1  asynchronous active-low reset.
- `m0_cyc_i, m0_stb_i, m0_we_i`  in  1 each  master 0 cycle, strobe and write enable.
- `m0_sel_i`  in  dw/8  master 0 byte selects.
- `m0_addr_i`  in  aw  master 0 address.
- `m0_dat_i`  in  dw  master 0 write data.
- `m0_dat_o`  out  dw  master 0 read data.
- `m0_ack_o, m0_err_o`  out  1 each  master 0 acknowledge and error.
- `m1_*`  same set as m0, for master 1.
- `s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_dat_o`  out  as master  signals to the controller's Wishbone slave.
- `s_dat_i`  in  dw  read data from the controller.
- `s_ack_i`  in  1  acknowledge from the controller.
- `grant_o`  out  2  one-hot current grant; 00 when no master is granted.
- `busy_o`  out  1  high in GRANT0 or GRANT1.

## Operation
- States: IDLE, GRANT0, GRANT1, ERR, RELEASE.
- The state, `last_grant`, the grant owner and the watchdog counter are registered.
- Output muxing and ack routing are combinational from the registered state.
- IDLE
  - Slave `cyc` and `stb` are 0.
  - If only `mN_cyc_i` is high, go to GRANTN.
  - If both are high, grant the master not equal to `last_grant`.
  - `last_grant` resets to 1, so master 0 wins the first contention.
  - `last_grant` is updated on entry to GRANTN.
- GRANTN
  - All `s_*` outputs follow master N directly.
  - `mN_dat_o` = `s_dat_i`; `mN_ack_o` = `s_ack_i`.
  - The other master sees ack=0 and err=0, and its `dat_o` is held at 0.
  - Stay in GRANTN while `mN_cyc_i`=1, so multi-beat and burst cycles are never split.
  - Go to IDLE when `mN_cyc_i`=0.
- Watchdog
  - Clears to 0 on `s_ack_i`, when `mN_stb_i`=0, and outside GRANT states.
  - Otherwise increments each cycle.
  - When it reaches TIMEOUT-1 with no ack that cycle, go to ERR.
- ERR
  - `s_cyc_o` and `s_stb_o` are 0.
  - `mN_err_o`=1 for exactly one cycle; `mN_ack_o`=0.
  - Next state is RELEASE.
- RELEASE
  - `s_cyc_o` and `s_stb_o` are 0.
  - Wait until `mN_cyc_i`=0, then go to IDLE.
  - A stray `s_ack_i` in IDLE, ERR or RELEASE is ignored and forwarded to no master.
- Only the `s_cyc_o`/`s_stb_o` gating and the ack/err routing depend on state; the slave's `we`, `sel`, `addr` and `dat` may show master 0 values when idle.

## Timing
- Reset (asynchronous, `wb_rst_n`=0)
  - State is IDLE; `grant_o`=00; `busy_o`=0; watchdog is 0; `last_grant`=1.
  - All `s_*` outputs, `mN_ack_o`, `mN_err_o` and `mN_dat_o` are 0.
  - Reset asserted mid-transfer drops `s_cyc_o` immediately; no err is generated.
- Grant latency: `mN_cyc_i` rising in cycle k gives `s_cyc_o`=1 in cycle k+1 when the arbiter is IDLE.
- Ack and read data are combinational: 0 cycles from `s_ack_i` to `mN_ack_o`.
- Handover: a master dropping `cyc` in cycle k puts IDLE in k+1 and the other master's grant in k+2. There is always one idle bus cycle between owners.
- If `s_ack_i` and watchdog expiry fall in the same cycle, the ack wins, the counter clears and there is no err.
- If `mN_cyc_i` drops and `s_ack_i` arrives in the same cycle, the ack is forwarded and the next state is IDLE.
- Watchdog timing: err asserts exactly TIMEOUT cycles after the first un-acked `stb` cycle.

## Test plan
- Reset release with no requests -> `grant_o`=00, all `s_*`=0, no acks for 20 cycles.
- m0 single write (addr 0x100, data 0xDEADBEEF, sel 4'hF) -> `s_cyc_o` high one cycle after `m0_cyc_i`; `m0_ack_o` mirrors `s_ack_i`; `m1_ack_o` stays 0.
- Both masters raise `cyc` in the same cycle, each doing 4-beat bursts, repeated 3 times -> grant order 0,1,0,1,0,1; one idle cycle between owners; no burst interleaving.
- m1 holds `cyc` for a 16-beat burst while m0 requests -> m0 is granted only after m1 drops `cyc`; all 16 m1 acks are delivered in order.
- TIMEOUT=8 and the controller never acks an m0 read -> `m0_err_o` pulses exactly at cycle 8 of `stb`; `s_stb_o` drops; the arbiter stays in RELEASE until `m0_cyc_i`=0; a later m1 request is granted normally.
- Reset asserted during an m1 burst -> all outputs go to 0 without waiting for a clock; after release, the first contention grants m0.

Source files
------------

// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single slave port of sdrc_top.
// Latency: grant one cycle after cyc in IDLE; ack and read data are combinational (0 cycles).
// Backpressure: the grant is held for the owner's whole cyc; a watchdog errors an un-acked stb after TIMEOUT cycles.
//
// Ports:
//   wb_clk_i / wb_rst_n     clock (rising edge) and asynchronous active-low reset
//   m0_* / m1_*             master-side Wishbone (cyc, stb, we, sel, addr, dat in; dat, ack, err out)
//   s_*                     controller-side Wishbone towards sdrc_top
//   grant_o                 one-hot current owner, 00 when no master holds the bus
//   busy_o                  high while a master is granted
module wb_sdram_arbiter #(
  parameter int dw      = 32,
  parameter int aw      = 26,
  parameter int TIMEOUT = 1024   // legal range 2..65535
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [dw/8-1:0] m0_sel_i,
  input  logic [aw-1:0]   m0_addr_i,
  input  logic [dw-1:0]   m0_dat_i,
  output logic [dw-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [dw/8-1:0] m1_sel_i,
  input  logic [aw-1:0]   m1_addr_i,
  input  logic [dw-1:0]   m1_dat_i,
  output logic [dw-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [dw/8-1:0] s_sel_o,
  output logic [aw-1:0]   s_addr_o,
  output logic [dw-1:0]   s_dat_o,
  input  logic [dw-1:0]   s_dat_i,
  input  logic            s_ack_i,

  output logic [1:0]      grant_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT0  = 3'd1,
    GRANT1  = 3'd2,
    ERR     = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // Watchdog compare value; the counter never exceeds it, so 16 bits cover the full range.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  // last_grant doubles as the owner of the bus: it is written on entry to GRANTn and
  // stays put through ERR and RELEASE, which is exactly when the owner must be known.
  logic        last_grant;
  logic        last_grant_nxt;
  logic [15:0] wd_cnt;
  logic [15:0] wd_cnt_nxt;

  logic        own_cyc;
  logic        own_stb;

  assign own_cyc = last_grant ? m1_cyc_i : m0_cyc_i;
  assign own_stb = last_grant ? m1_stb_i : m0_stb_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // master 0 wins the first contention after reset
      wd_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wd_cnt     <= wd_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, round-robin choice and watchdog
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wd_cnt_nxt     = '0;        // cleared everywhere except while counting a stalled stb

    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Contention: hand the bus to whoever did not have it last.
          if (last_grant) begin
            state_nxt      = GRANT0;
            last_grant_nxt = 1'b0;
          end else begin
            state_nxt      = GRANT1;
            last_grant_nxt = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
        end
      end

      GRANT0, GRANT1: begin
        if (!own_cyc) begin
          // Owner ended its cycle; an ack arriving now is still forwarded combinationally.
          state_nxt = IDLE;
        end else if (own_stb && !s_ack_i) begin
          // An ack in the expiry cycle takes precedence, so only un-acked strobes expire.
          if (wd_cnt == WD_LAST) begin
            state_nxt = ERR;
          end else begin
            wd_cnt_nxt = wd_cnt + 16'd1;
          end
        end
      end

      ERR: begin
        state_nxt = RELEASE;
      end

      RELEASE: begin
        // Hold the bus away from everyone until the erroring master closes its cycle.
        if (!own_cyc) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output muxing and ack/err routing, purely from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    // Address-side fields default to master 0; only cyc/stb gate the controller.
    s_we_o   = m0_we_i;
    s_sel_o  = m0_sel_i;
    s_addr_o = m0_addr_i;
    s_dat_o  = m0_dat_i;
    m0_dat_o = '0;
    m1_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    busy_o   = 1'b0;

    case (state)
      GRANT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        grant_o  = 2'b01;
        busy_o   = 1'b1;
      end

      GRANT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        grant_o  = 2'b10;
        busy_o   = 1'b1;
      end

      ERR: begin
        // Single-cycle error to the owner; any stray s_ack_i is dropped here.
        if (last_grant) begin
          m1_err_o = 1'b1;
        end else begin
          m0_err_o = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: behavioural burst masters, a randomly
// stalling slave and per-scenario checks of grant order, ack routing and watchdog.
module tb_wb_sdram_arbiter;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m_cyc  [2];
  logic          m_stb  [2];
  logic          m_we   [2];
  logic [3:0]    m_sel  [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdat [2];
  logic [DW-1:0] m_rdat [2];
  logic          m_ack  [2];
  logic          m_err  [2];

  logic          s_cyc, s_stb, s_we;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdat;
  logic [DW-1:0] s_rdat;
  logic          s_ack;
  logic [1:0]    grant;
  logic          busy;

  wb_sdram_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .m0_cyc_i (m_cyc[0]),  .m0_stb_i (m_stb[0]),  .m0_we_i (m_we[0]),
    .m0_sel_i (m_sel[0]),  .m0_addr_i(m_addr[0]), .m0_dat_i(m_wdat[0]),
    .m0_dat_o (m_rdat[0]), .m0_ack_o (m_ack[0]),  .m0_err_o(m_err[0]),
    .m1_cyc_i (m_cyc[1]),  .m1_stb_i (m_stb[1]),  .m1_we_i (m_we[1]),
    .m1_sel_i (m_sel[1]),  .m1_addr_i(m_addr[1]), .m1_dat_i(m_wdat[1]),
    .m1_dat_o (m_rdat[1]), .m1_ack_o (m_ack[1]),  .m1_err_o(m_err[1]),
    .s_cyc_o  (s_cyc),     .s_stb_o  (s_stb),     .s_we_o  (s_we),
    .s_sel_o  (s_sel),     .s_addr_o (s_addr),    .s_dat_o (s_wdat),
    .s_dat_i  (s_rdat),    .s_ack_i  (s_ack),
    .grant_o  (grant),     .busy_o   (busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int m; logic [AW-1:0] addr; logic [DW-1:0] dat; } ack_t;
  typedef struct { int cyc; int m; } err_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] dat; } wr_t;

  ack_t       ack_q[$];
  err_t       err_q[$];
  wr_t        wlog[$];
  logic [1:0] gnt_hist[$];
  bit         stb_hist[$];
  bit         scyc_hist[$];
  bit         mcyc0_hist[$];
  int         t_own[$], t_st[$], t_en[$];
  int         cyc_no;
  int         stray;

  // Master models: mm_bursts bursts of mm_len beats, cyc low for one cycle between bursts.
  int            mm_len[2], mm_bursts[2], mm_beat[2], mm_gap[2];
  int            mm_errhold[2], mm_hold_cfg[2], mm_wmode[2];
  bit            mm_act[2], mm_in_err[2], mm_we[2];
  logic [AW-1:0] mm_base[2];

  // Slave model: acks after sl_wait stalled cycles; optionally never acks master-0 addresses.
  bit sl_en, sl_noack_m0;
  int sl_fixed, sl_wait;

  function automatic logic [DW-1:0] rd_hash(input logic [AW-1:0] a);
    return 32'(a) * 32'h0001_0003 ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [DW-1:0] wr_hash(input logic [AW-1:0] a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic clear_env();
    ack_q.delete(); err_q.delete(); wlog.delete();
    gnt_hist.delete(); stb_hist.delete(); scyc_hist.delete(); mcyc0_hist.delete();
    cyc_no = 0; stray = 0;
    sl_en = 1'b1; sl_noack_m0 = 1'b0; sl_fixed = -1; sl_wait = 0; s_ack = 1'b0; s_rdat = '0;
    for (int n = 0; n < 2; n++) begin
      mm_len[n] = 1; mm_bursts[n] = 0; mm_beat[n] = 0; mm_gap[n] = 0;
      mm_errhold[n] = 0; mm_hold_cfg[n] = 0; mm_wmode[n] = 0;
      mm_act[n] = 1'b0; mm_in_err[n] = 1'b0; mm_we[n] = 1'b0; mm_base[n] = '0;
      m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0; m_sel[n] = 4'h0;
      m_addr[n] = '0; m_wdat[n] = '0;
    end
  endtask

  task automatic drive_masters();
    for (int n = 0; n < 2; n++) begin
      if (mm_in_err[n]) begin
        if (mm_errhold[n] > 0) mm_errhold[n]--;
        else begin
          mm_act[n] = 1'b0; mm_in_err[n] = 1'b0; mm_bursts[n] = 0;
        end
      end else if (!mm_act[n] && mm_bursts[n] > 0) begin
        if (mm_gap[n] > 0) mm_gap[n]--;
        else begin
          mm_act[n]  = 1'b1;
          mm_beat[n] = 0;
          mm_base[n] = {5'b0, 1'(n), 14'($urandom_range(0, 16383)), 6'b0};
          mm_we[n]   = (mm_wmode[n] == 2) ? 1'($urandom_range(0, 1)) : 1'(mm_wmode[n]);
        end
      end
      m_cyc[n]  = mm_act[n];
      m_stb[n]  = mm_act[n] && !mm_in_err[n];
      m_we[n]   = mm_act[n] && mm_we[n];
      m_sel[n]  = mm_act[n] ? 4'hF : 4'h0;
      m_addr[n] = mm_act[n] ? mm_base[n] + AW'(mm_beat[n] * 4) : '0;
      m_wdat[n] = (mm_act[n] && mm_we[n]) ? wr_hash(m_addr[n]) : '0;
    end
  endtask

  task automatic drive_slave();
    s_rdat = rd_hash(s_addr);
    if (sl_en)
      s_ack = s_cyc && s_stb && !(sl_noack_m0 && !s_addr[20]) && (sl_wait == 0);
  endtask

  task automatic sample();
    gnt_hist.push_back(grant);
    stb_hist.push_back(s_stb);
    scyc_hist.push_back(s_cyc);
    mcyc0_hist.push_back(m_cyc[0]);
    if ((m_ack[0] && m_ack[1]) || grant == 2'b11) stray++;
    for (int n = 0; n < 2; n++) begin
      if (m_ack[n]) begin
        if (grant != 2'(1 << n)) stray++;
        ack_q.push_back('{cyc_no, n, m_addr[n], m_rdat[n]});
        mm_beat[n]++;
        if (mm_beat[n] >= mm_len[n]) begin
          mm_act[n] = 1'b0; mm_bursts[n]--; mm_gap[n] = 1;
        end
      end
      if (m_err[n]) begin
        err_q.push_back('{cyc_no, n});
        mm_in_err[n] = 1'b1;
        mm_errhold[n] = mm_hold_cfg[n];
      end
    end
    if (s_ack && s_cyc && s_stb && s_we) wlog.push_back('{s_addr, s_wdat});
    if (s_cyc && s_stb) begin
      if (s_ack) sl_wait = (sl_fixed >= 0) ? sl_fixed : $urandom_range(0, 2);
      else if (sl_wait > 0) sl_wait--;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_masters(); #1;
      drive_slave();   #1;
      sample();
      cyc_no++;
    end
  endtask

  // Splits the grant history into contiguous ownership periods.
  task automatic find_tenures();
    t_own.delete(); t_st.delete(); t_en.delete();
    for (int i = 0; i < gnt_hist.size(); i++) begin
      if (gnt_hist[i] != 2'b00 && (i == 0 || gnt_hist[i-1] != gnt_hist[i])) begin
        t_own.push_back(gnt_hist[i] == 2'b10 ? 1 : 0);
        t_st.push_back(i);
        t_en.push_back(i);
      end else if (gnt_hist[i] != 2'b00) begin
        t_en[t_en.size()-1] = i;
      end
    end
  endtask

  task automatic test_reset();
    int act;
    clear_env();
    #3;
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, s_addr, s_wdat, grant, busy} !== '0) begin
      errors++;
      $display("FAIL reset_slave_side: got cyc=%b stb=%b grant=%b busy=%b addr=%h, required all 0",
               s_cyc, s_stb, grant, busy, s_addr);
    end
    checks++;
    if ({m_ack[0], m_ack[1], m_err[0], m_err[1]} !== 4'b0 || m_rdat[0] !== '0 || m_rdat[1] !== '0) begin
      errors++;
      $display("FAIL reset_master_side: got ack=%b%b err=%b%b, required 0", m_ack[0], m_ack[1], m_err[0], m_err[1]);
    end
    @(negedge clk) rst_n = 1'b1;
    run_cycles(20);
    act = 0;
    for (int i = 0; i < gnt_hist.size(); i++) act += int'(gnt_hist[i] != 2'b00) + int'(scyc_hist[i]) + int'(stb_hist[i]);
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_idle_quiet: got %0d active grant/cyc/stb samples, required 0", act);
    end
    checks++;
    if (ack_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_acks: got %0d acks, required 0", ack_q.size());
    end
  endtask

  task automatic test_contention();
    int cnt, bad;
    clear_env();
    for (int n = 0; n < 2; n++) begin
      mm_len[n] = 4; mm_bursts[n] = 3; mm_wmode[n] = 2;
    end
    run_cycles(200);
    find_tenures();
    checks++;
    if (t_own.size() != 6) begin
      errors++;
      $display("FAIL contention_tenures: got %0d tenures, required 6", t_own.size());
    end
    for (int i = 0; i < t_own.size() && i < 6; i++) begin
      checks++;
      if (t_own[i] != i % 2) begin
        errors++;
        $display("FAIL contention_order[%0d]: got master %0d, required %0d", i, t_own[i], i % 2);
      end
      cnt = 0; bad = 0;
      foreach (ack_q[j]) begin
        if (ack_q[j].cyc >= t_st[i] && ack_q[j].cyc <= t_en[i]) begin
          cnt++;
          if (ack_q[j].m != i % 2) bad++;
        end
      end
      checks++;
      if (cnt != 4 || bad != 0) begin
        errors++;
        $display("FAIL contention_burst[%0d]: got %0d beats (%0d foreign), required 4 (0)", i, cnt, bad);
      end
      if (i > 0) begin
        checks++;
        if (t_st[i] - t_en[i-1] - 1 != 1) begin
          errors++;
          $display("FAIL contention_gap[%0d]: got %0d idle cycles, required 1", i, t_st[i] - t_en[i-1] - 1);
        end
      end
    end
    foreach (ack_q[j]) begin
      checks++;
      if (ack_q[j].dat !== rd_hash(ack_q[j].addr)) begin
        errors++;
        $display("FAIL contention_rdata: got %h, required %h", ack_q[j].dat, rd_hash(ack_q[j].addr));
      end
    end
    foreach (wlog[j]) begin
      checks++;
      if (wlog[j].dat !== wr_hash(wlog[j].addr)) begin
        errors++;
        $display("FAIL contention_wdata: got %h, required %h", wlog[j].dat, wr_hash(wlog[j].addr));
      end
    end
    checks++;
    if (stray != 0 || mm_bursts[0] != 0 || mm_bursts[1] != 0) begin
      errors++;
      $display("FAIL contention_done: got stray=%0d left=%0d/%0d, required 0/0/0", stray, mm_bursts[0], mm_bursts[1]);
    end
  endtask

  task automatic test_single_write();
    logic [DW-1:0] rd;
    clear_env();
    sl_en = 1'b0;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[0] = 4'hF;
    m_addr[0] = 26'h100; m_wdat[0] = 32'hDEAD_BEEF;
    #2;
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL write_latency_early: got s_cyc=%b, required 0", s_cyc);
    end
    @(posedge clk); #2;
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, s_addr, s_wdat, grant} !== {1'b1, 1'b1, 1'b1, 4'hF, 26'h100, 32'hDEAD_BEEF, 2'b01}) begin
      errors++;
      $display("FAIL write_slave_bus: got cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h grant=%b, required 1 1 1 f 100 deadbeef 01",
               s_cyc, s_stb, s_we, s_sel, s_addr, s_wdat, grant);
    end
    rd = $urandom;
    s_rdat = rd; s_ack = 1'b1; #1;
    checks++;
    if (m_ack[0] !== 1'b1 || m_rdat[0] !== rd) begin
      errors++;
      $display("FAIL write_ack0: got ack=%b dat=%h, required 1 %h", m_ack[0], m_rdat[0], rd);
    end
    checks++;
    if (m_ack[1] !== 1'b0 || m_rdat[1] !== '0 || m_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL write_other_master: got ack=%b dat=%h err=%b, required 0 0 0", m_ack[1], m_rdat[1], m_err[1]);
    end
    s_ack = 1'b0; #1;
    checks++;
    if (m_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_mirror: got ack=%b, required 0", m_ack[0]);
    end
    s_ack = 1'b1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0; s_ack = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_release: got grant=%b cyc=%b busy=%b, required 00 0 0", grant, s_cyc, busy);
    end
    clear_env();
  endtask

  task automatic test_long_burst();
    int n1, bad;
    logic [AW-1:0] a0;
    clear_env();
    mm_len[1] = 16; mm_bursts[1] = 1; mm_wmode[1] = 0;
    mm_len[0] = 2;  mm_bursts[0] = 1; mm_wmode[0] = 1; mm_gap[0] = 3;
    run_cycles(120);
    find_tenures();
    checks++;
    if (t_own.size() != 2) begin
      errors++;
      $display("FAIL burst_tenures: got %0d, required 2", t_own.size());
    end else begin
      checks++;
      if (t_own[0] != 1 || t_own[1] != 0) begin
        errors++;
        $display("FAIL burst_owner_order: got %0d,%0d, required 1,0", t_own[0], t_own[1]);
      end
      checks++;
      if (t_st[1] != t_en[0] + 2) begin
        errors++;
        $display("FAIL burst_handover: got m0 grant at %0d, required %0d", t_st[1], t_en[0] + 2);
      end
    end
    n1 = 0; bad = 0; a0 = '0;
    foreach (ack_q[j]) begin
      if (ack_q[j].m == 1) begin
        if (n1 == 0) a0 = ack_q[j].addr;
        if (ack_q[j].addr !== a0 + AW'(n1 * 4) || ack_q[j].dat !== rd_hash(ack_q[j].addr)) bad++;
        n1++;
      end
    end
    checks++;
    if (n1 != 16 || bad != 0) begin
      errors++;
      $display("FAIL burst_m1_beats: got %0d beats (%0d out of order/bad data), required 16 (0)", n1, bad);
    end
    checks++;
    if (stray != 0 || wlog.size() != 2) begin
      errors++;
      $display("FAIL burst_m0_service: got stray=%0d writes=%0d, required 0 2", stray, wlog.size());
    end
  endtask

  task automatic test_watchdog();
    int first_stb, e, drop, leak, g1, m0acks, m1acks;
    // A stall of TIMEOUT-1 cycles acked in the expiry cycle must not error.
    clear_env();
    sl_fixed = TO - 1; sl_wait = TO - 1;
    mm_len[0] = 1; mm_bursts[0] = 1; mm_wmode[0] = 0;
    run_cycles(30);
    checks++;
    if (ack_q.size() != 1 || err_q.size() != 0) begin
      errors++;
      $display("FAIL wd_ack_wins: got acks=%0d errs=%0d, required 1 0", ack_q.size(), err_q.size());
    end
    // Never-acked read: err, release hold, then m1 served.
    clear_env();
    sl_noack_m0 = 1'b1;
    mm_len[0] = 1; mm_bursts[0] = 1; mm_wmode[0] = 0; mm_hold_cfg[0] = 5;
    mm_len[1] = 1; mm_bursts[1] = 1; mm_wmode[1] = 2; mm_gap[1] = 12;
    run_cycles(60);
    first_stb = -1;
    foreach (stb_hist[i]) if (stb_hist[i] && first_stb < 0) first_stb = i;
    checks++;
    if (err_q.size() != 1) begin
      errors++;
      $display("FAIL wd_err_count: got %0d err pulses, required 1", err_q.size());
    end else begin
      e = err_q[0].cyc;
      checks++;
      if (err_q[0].m != 0 || e != first_stb + TO) begin
        errors++;
        $display("FAIL wd_err_timing: got master %0d cycle %0d, required master 0 cycle %0d", err_q[0].m, e, first_stb + TO);
      end
      drop = -1;
      for (int i = e; i < mcyc0_hist.size(); i++) if (!mcyc0_hist[i] && drop < 0) drop = i;
      leak = 0;
      for (int i = e; i <= drop && i >= 0; i++) leak += int'(scyc_hist[i]) + int'(stb_hist[i]) + int'(gnt_hist[i] != 2'b00);
      checks++;
      if (drop < 0 || leak != 0) begin
        errors++;
        $display("FAIL wd_release_hold: got drop=%0d leaked=%0d, required drop>=0 leaked=0", drop, leak);
      end
      find_tenures();
      g1 = -1;
      foreach (t_own[i]) if (t_own[i] == 1 && g1 < 0) g1 = t_st[i];
      checks++;
      if (g1 != drop + 2) begin
        errors++;
        $display("FAIL wd_m1_grant: got cycle %0d, required %0d", g1, drop + 2);
      end
    end
    m0acks = 0; m1acks = 0;
    foreach (ack_q[j]) if (ack_q[j].m == 0) m0acks++; else m1acks++;
    checks++;
    if (m0acks != 0 || m1acks != 1 || stray != 0) begin
      errors++;
      $display("FAIL wd_acks: got m0=%0d m1=%0d stray=%0d, required 0 1 0", m0acks, m1acks, stray);
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_env();
    mm_len[1] = 16; mm_bursts[1] = 1; mm_wmode[1] = 0;
    run_cycles(6);
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL midrst_pre_grant: got %b, required 10", grant);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, s_addr, s_wdat, grant, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got cyc=%b stb=%b grant=%b busy=%b addr=%h, required all 0",
               s_cyc, s_stb, grant, busy, s_addr);
    end
    checks++;
    if (m_ack[1] !== 1'b0 || m_rdat[1] !== '0 || m_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_m1_out: got ack=%b dat=%h err=%b, required 0 0 0", m_ack[1], m_rdat[1], m_err[1]);
    end
    clear_env();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      mm_len[n] = 2; mm_bursts[n] = 1; mm_wmode[n] = 2;
    end
    run_cycles(40);
    find_tenures();
    checks++;
    if (t_own.size() != 2 || t_own[0] != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_first_contention: got tenures=%0d first=%0d errs=%0d, required 2 0 0",
               t_own.size(), (t_own.size() > 0) ? t_own[0] : -1, err_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_long_burst();
    test_watchdog();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000 ns, required to finish earlier");
    $fatal(1);
  end

endmodule
